// File: rtl/cordic_op_sequencer_if.sv
// Bus between the CORDIC op sequencer and its host: table-write port, run control,
// and the switch/press/status signals. The loop input exists only with CORDIC_SEQ_LOOP_EN.
interface cordic_op_sequencer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned FUNC_W = 4
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;
    logic [FUNC_W-1:0] wr_func;
    logic              wr_two;
    logic [DATA_W-1:0] wr_a;
    logic [DATA_W-1:0] wr_b;
    logic [CNT_W-1:0]  num_ops;
    logic              start;
`ifdef CORDIC_SEQ_LOOP_EN
    logic              loop;
`endif
    logic [DATA_W-1:0] sw_out;
    logic              st;
    logic              busy;
    logic              done;
    logic [IDX_W-1:0]  cur_idx;

    modport master (
        output wr_en, wr_addr, wr_func, wr_two, wr_a, wr_b, num_ops, start,
`ifdef CORDIC_SEQ_LOOP_EN
        output loop,
`endif
        input  sw_out, st, busy, done, cur_idx
    );

    modport slave (
        input  wr_en, wr_addr, wr_func, wr_two, wr_a, wr_b, num_ops, start,
`ifdef CORDIC_SEQ_LOOP_EN
        input  loop,
`endif
        output sw_out, st, busy, done, cur_idx
    );
endinterface

// File: rtl/cordic_op_sequencer.sv
// Replays a table of (func, A, B) entries into the CORDIC switch/start-button front end.
// Define CORDIC_SEQ_LOOP_EN to add the loop input that restarts the table instead of finishing.
module cordic_op_sequencer #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned FUNC_W      = 4,
    parameter int unsigned HOLD_CYCLES = 20
) (
    input logic                  clk,
    input logic                  rst_n,
    cordic_op_sequencer_if.slave bus
);
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        StIdle, StWake, StSelect, StEnter1, StEnter2, StRun, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] sw_q, sw_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [FUNC_W-1:0] func_mem [DEPTH];
    logic              two_mem  [DEPTH];
    logic [DATA_W-1:0] a_mem    [DEPTH];
    logic [DATA_W-1:0] b_mem    [DEPTH];

    logic              in_step, press, last_entry, loop_req;
    logic [CNT_W-1:0]  idx_inc;
    logic [DATA_W-1:0] step_val;

`ifdef CORDIC_SEQ_LOOP_EN
    assign loop_req = bus.loop;
`else
    assign loop_req = 1'b0;
`endif

    // Table is deliberately not reset; writes land only while idle.
    always_ff @(posedge clk) begin
        if (bus.wr_en && state_q == StIdle) begin
            func_mem[bus.wr_addr] <= bus.wr_func;
            two_mem[bus.wr_addr]  <= bus.wr_two;
            a_mem[bus.wr_addr]    <= bus.wr_a;
            b_mem[bus.wr_addr]    <= bus.wr_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            count_q <= '0;
            sw_q    <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            sw_q    <= sw_d;
            hold_q  <= hold_d;
        end
    end

    assign idx_inc    = CNT_W'(idx_q) + CNT_W'(1);
    assign last_entry = !(idx_inc < count_q);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        count_d  = count_q;
        sw_d     = sw_q;
        hold_d   = hold_q;
        step_val = '0;
        if (in_step && !press) begin
            hold_d = hold_q + HOLD_W'(1);
        end
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.num_ops == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StWake;
                        idx_d   = '0;
                        count_d = (bus.num_ops > DEPTH_CNT) ? DEPTH_CNT : bus.num_ops;
                    end
                end
            end
            StWake:   if (press) state_d = StSelect;
            StSelect: if (press) state_d = two_mem[idx_q] ? StEnter1 : StEnter2;
            StEnter1: if (press) state_d = StEnter2;
            StEnter2: if (press) state_d = StRun;
            StRun: begin
                if (press) begin
                    if (!last_entry) begin
                        state_d = StSelect;
                        idx_d   = IDX_W'(idx_inc);
                    end else if (loop_req) begin
                        state_d = StSelect;
                        idx_d   = '0;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        case (state_d)
            StSelect: step_val = DATA_W'(func_mem[idx_d]);
            StEnter1: step_val = a_mem[idx_d];
            StEnter2, StRun: step_val = b_mem[idx_d];
            default:  step_val = '0;
        endcase

        // Every step begins with a fresh hold count and its own switch value.
        if (state_d != state_q && state_d != StIdle && state_d != StDone) begin
            hold_d = '0;
            sw_d   = step_val;
        end
    end

    always_comb begin
        in_step  = (state_q != StIdle) && (state_q != StDone);
        press    = in_step && (hold_q == HOLD_LAST);
        bus.st   = press;
        bus.busy = in_step;
        bus.done = (state_q == StDone);
    end

    assign bus.sw_out  = sw_q;
    assign bus.cur_idx = idx_q;

endmodule
